// File: rtl/lfsr_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lfsr_pkg : shared constants and state type for the LFSR checker  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package lfsr_pkg;

  localparam int LFSR_W = 10;
  localparam int TAP_A  = 8;
  localparam int TAP_B  = 9;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr_history.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lfsr_history : 10-stage history register with next-bit predictor |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module lfsr_history
  import lfsr_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic sel_pred,
  input  logic bit_in,
  output logic pred,
  output logic all_zero
);

  logic [LFSR_W-1:0] r_hist;
  logic              w_din;

  assign pred     = r_hist[TAP_A] ^ r_hist[TAP_B];
  assign w_din    = sel_pred ? pred : bit_in;
  // Zero test looks at the value being loaded, not the current contents.
  assign all_zero = ~|{r_hist[LFSR_W-2:0], w_din};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= '0;
    end else if (shift_en) begin
      r_hist <= {r_hist[LFSR_W-2:0], w_din};
    end
  end

endmodule
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lfsr_checker : self-synchronising checker for the 10-stage LFSR  |
// | stream with lock FSM, windowed loss detection, saturating counts |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 16,
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_counts,
  output logic             locked,
  output logic             error_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int FC_W = $clog2(LFSR_W + 1);
  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int WB_W = $clog2(WINDOW + 1);
  localparam int WE_W = $clog2(ERR_THRESH + 1);

  localparam logic [FC_W-1:0] c_fill_last  = FC_W'(LFSR_W - 1);
  localparam logic [MC_W-1:0] c_match_last = MC_W'(LOCK_COUNT - 1);
  localparam logic [WB_W-1:0] c_win_last   = WB_W'(WINDOW - 1);
  localparam logic [WE_W-1:0] c_err_thresh = WE_W'(ERR_THRESH);

  chk_state_t       r_state, w_state_next;
  logic [FC_W-1:0]  r_fill_cnt, w_fill_next;
  logic [MC_W-1:0]  r_match_cnt, w_match_next;
  logic [WB_W-1:0]  r_win_bits, w_win_bits_next;
  logic [WE_W-1:0]  r_win_err, w_win_err_next, w_win_err_sum;
  logic             w_shift, w_sel_pred, w_chk_bit, w_err_bit;
  logic             w_pred, w_all_zero, w_mismatch;
  logic             r_locked, r_error_pulse;
  logic [CNT_W-1:0] r_err_count, r_bit_count;

  lfsr_history u_history (
    .clk      (clk),
    .reset    (reset),
    .shift_en (w_shift),
    .sel_pred (w_sel_pred),
    .bit_in   (bit_in),
    .pred     (w_pred),
    .all_zero (w_all_zero)
  );

  assign w_mismatch    = bit_in ^ w_pred;
  assign w_win_err_sum = r_win_err + WE_W'(w_mismatch);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HUNT;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_bits  <= '0;
      r_win_err   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_fill_cnt  <= w_fill_next;
      r_match_cnt <= w_match_next;
      r_win_bits  <= w_win_bits_next;
      r_win_err   <= w_win_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_fill_next     = r_fill_cnt;
    w_match_next    = r_match_cnt;
    w_win_bits_next = r_win_bits;
    w_win_err_next  = r_win_err;
    w_shift         = 1'b0;
    w_sel_pred      = 1'b0;
    w_chk_bit       = 1'b0;
    w_err_bit       = 1'b0;
    if (bit_valid) begin
      w_shift = 1'b1;
      case (r_state)
        HUNT: begin
          if (r_fill_cnt == c_fill_last) begin
            w_state_next = VERIFY;
            w_fill_next  = '0;
            w_match_next = '0;
          end else begin
            w_fill_next = r_fill_cnt + FC_W'(1);
          end
        end
        VERIFY: begin
          if (w_mismatch) begin
            w_match_next = '0;
          end else if (r_match_cnt == c_match_last) begin
            w_match_next    = '0;
            w_win_bits_next = '0;
            w_win_err_next  = '0;
            if (w_all_zero) begin
              w_state_next = HUNT;
              w_fill_next  = '0;
            end else begin
              w_state_next = LOCKED;
            end
          end else begin
            w_match_next = r_match_cnt + MC_W'(1);
          end
        end
        LOCKED: begin
          w_sel_pred = 1'b1;
          w_chk_bit  = 1'b1;
          w_err_bit  = w_mismatch;
          // Threshold is tested before rollover so a last-bit error still counts.
          if (w_win_err_sum == c_err_thresh) begin
            w_state_next    = HUNT;
            w_fill_next     = '0;
            w_win_bits_next = '0;
            w_win_err_next  = '0;
          end else if (r_win_bits == c_win_last) begin
            w_win_bits_next = '0;
            w_win_err_next  = '0;
          end else begin
            w_win_bits_next = r_win_bits + WB_W'(1);
            w_win_err_next  = w_win_err_sum;
          end
        end
        default: begin
          w_state_next = HUNT;
          w_fill_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_locked      <= 1'b0;
      r_error_pulse <= 1'b0;
      r_err_count   <= '0;
      r_bit_count   <= '0;
    end else begin
      r_locked      <= (w_state_next == LOCKED);
      r_error_pulse <= w_err_bit;
      if (clear_counts) begin
        r_err_count <= '0;
        r_bit_count <= '0;
      end else begin
        if (w_chk_bit && (r_bit_count != '1)) r_bit_count <= r_bit_count + CNT_W'(1);
        if (w_err_bit && (r_err_count != '1)) r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

  assign locked      = r_locked;
  assign error_pulse = r_error_pulse;
  assign err_count   = r_err_count;
  assign bit_count   = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lfsr_checker : scenario bench for lfsr_checker                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_lfsr_checker;
  import lfsr_pkg::*;

  localparam int LOCK_COUNT = 16;
  localparam int WINDOW     = 64;
  localparam int ERR_THRESH = 4;
  localparam int CNT_W      = 16;
  localparam int LOCK_BITS  = LFSR_W + LOCK_COUNT;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             clear_counts = 1'b0;
  logic             locked, error_pulse;
  logic [CNT_W-1:0] err_count, bit_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic pulse;
    logic lock;
  } exp_t;

  exp_t              sb[$];
  exp_t              exp_v;
  logic [LFSR_W-1:0] gen;

  always #5 clk = ~clk;

  lfsr_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .WINDOW     (WINDOW),
    .ERR_THRESH (ERR_THRESH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .clear_counts (clear_counts),
    .locked       (locked),
    .error_pulse  (error_pulse),
    .err_count    (err_count),
    .bit_count    (bit_count)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  task automatic do_reset(input bit reseed);
    @(negedge clk);
    reset = 1'b1; bit_valid = 1'b0; clear_counts = 1'b0; bit_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    if (reseed) gen = 10'h001;
    sb.delete();
  endtask

  // Drives one cycle; on a valid cycle the generator advances and inv flips the sent bit.
  task automatic step(input logic v, input logic inv, input logic clr, input logic ep, input logic el);
    logic b;
    @(negedge clk);
    if (v) begin
      b      = gen[TAP_A] ^ gen[TAP_B];
      gen    = {gen[LFSR_W-2:0], b};
      bit_in = b ^ inv;
    end else begin
      bit_in = 1'($urandom_range(0, 1));
    end
    bit_valid    = v;
    clear_counts = clr;
    sb.push_back(exp_t'({ep, el}));
    @(posedge clk); #1;
    bit_valid    = 1'b0;
    clear_counts = 1'b0;
  endtask

  task automatic bring_up();
    do_reset(1'b1);
    for (int k = 1; k <= LOCK_BITS; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    total += 4;
    if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked); end
    if (error_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b want=0", error_pulse); end
    if (err_count !== '0) begin bad++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
    if (bit_count !== '0) begin bad++; $display("FAIL reset_bit_count got=%0d want=0", bit_count); end
  endtask

  task automatic test_clean_lock();
    do_reset(1'b1);
    for (int k = 1; k <= LOCK_BITS + 1000; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, logic'(k >= LOCK_BITS));
      exp_v = sb.pop_front(); total++;
      if (error_pulse !== exp_v.pulse || locked !== exp_v.lock) begin
        bad++;
        $display("FAIL clean_lock bit=%0d got pulse=%b locked=%b want pulse=%b locked=%b",
                 k, error_pulse, locked, exp_v.pulse, exp_v.lock);
      end
    end
    total += 2;
    if (bit_count !== 16'd1000) begin bad++; $display("FAIL clean_bit_count got=%0d want=1000", bit_count); end
    if (err_count !== 16'd0) begin bad++; $display("FAIL clean_err_count got=%0d want=0", err_count); end
  endtask

  task automatic test_single_error();
    logic inv;
    bring_up();
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL single_prelock got=%b want=1", locked); end
    for (int i = 0; i < 140; i++) begin
      inv = logic'(i == 30);
      step(1'b1, inv, 1'b0, inv, 1'b1);
      exp_v = sb.pop_front(); total++;
      if (error_pulse !== exp_v.pulse || locked !== exp_v.lock) begin
        bad++;
        $display("FAIL single_error i=%0d got pulse=%b locked=%b want pulse=%b locked=%b",
                 i, error_pulse, locked, exp_v.pulse, exp_v.lock);
      end
    end
    total += 2;
    if (err_count !== 16'd1) begin bad++; $display("FAIL single_err_count got=%0d want=1", err_count); end
    if (bit_count !== 16'd140) begin bad++; $display("FAIL single_bit_count got=%0d want=140", bit_count); end
  endtask

  task automatic test_loss_of_lock();
    logic inv;
    bring_up();
    for (int i = 0; i < 12; i++) begin
      inv = logic'(i inside {5, 7, 9, 11});
      step(1'b1, inv, 1'b0, inv, logic'(i < 11));
      exp_v = sb.pop_front(); total++;
      if (error_pulse !== exp_v.pulse || locked !== exp_v.lock) begin
        bad++;
        $display("FAIL loss i=%0d got pulse=%b locked=%b want pulse=%b locked=%b",
                 i, error_pulse, locked, exp_v.pulse, exp_v.lock);
      end
    end
    total++;
    if (err_count !== 16'd4) begin bad++; $display("FAIL loss_err_count got=%0d want=4", err_count); end
    for (int k = 1; k <= LOCK_BITS; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, logic'(k >= LOCK_BITS));
      exp_v = sb.pop_front(); total++;
      if (error_pulse !== exp_v.pulse || locked !== exp_v.lock) begin
        bad++;
        $display("FAIL relock bit=%0d got pulse=%b locked=%b want pulse=%b locked=%b",
                 k, error_pulse, locked, exp_v.pulse, exp_v.lock);
      end
    end
    total += 2;
    if (err_count !== 16'd4) begin bad++; $display("FAIL relock_err_count got=%0d want=4", err_count); end
    if (bit_count !== 16'd12) begin bad++; $display("FAIL relock_bit_count got=%0d want=12", bit_count); end
  endtask

  // Windows span locked bits 0-63, 64-127, 128-191; the 4th error of the
  // third window lands on its last bit.
  task automatic test_window();
    logic inv;
    bring_up();
    for (int i = 0; i < 3 * WINDOW; i++) begin
      inv = logic'(i inside {61, 62, 63, 64, 65, 66, 138, 148, 158, 191});
      step(1'b1, inv, 1'b0, inv, logic'(i < 191));
      exp_v = sb.pop_front(); total++;
      if (error_pulse !== exp_v.pulse || locked !== exp_v.lock) begin
        bad++;
        $display("FAIL window i=%0d got pulse=%b locked=%b want pulse=%b locked=%b",
                 i, error_pulse, locked, exp_v.pulse, exp_v.lock);
      end
    end
    total++;
    if (err_count !== 16'd10) begin bad++; $display("FAIL window_err_count got=%0d want=10", err_count); end
  endtask

  task automatic test_degenerate();
    do_reset(1'b1);
    gen = '0;
    for (int k = 1; k <= 200; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); total++;
      if (error_pulse !== exp_v.pulse || locked !== exp_v.lock) begin
        bad++;
        $display("FAIL degenerate bit=%0d got pulse=%b locked=%b want pulse=%b locked=%b",
                 k, error_pulse, locked, exp_v.pulse, exp_v.lock);
      end
    end
  endtask

  task automatic test_gaps_clear();
    int   vc;
    logic v;
    do_reset(1'b1);
    vc = 0;
    for (int c = 0; c < 2000 && vc < 60; c++) begin
      v = 1'($urandom_range(0, 1));
      if (v) vc++;
      step(v, 1'b0, 1'b0, 1'b0, logic'(vc >= LOCK_BITS));
      exp_v = sb.pop_front(); total++;
      if (error_pulse !== exp_v.pulse || locked !== exp_v.lock) begin
        bad++;
        $display("FAIL gaps cycle=%0d valid_bits=%0d got pulse=%b locked=%b want pulse=%b locked=%b",
                 c, vc, error_pulse, locked, exp_v.pulse, exp_v.lock);
      end
    end
    total++;
    if (vc < 60) begin bad++; $display("FAIL gaps_budget got=%0d valid bits want=60", vc); end
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_v = sb.pop_front(); total += 2;
    if (error_pulse !== exp_v.pulse || locked !== exp_v.lock) begin
      bad++;
      $display("FAIL gaps_err got pulse=%b locked=%b want pulse=%b locked=%b",
               error_pulse, locked, exp_v.pulse, exp_v.lock);
    end
    if (err_count !== 16'd1) begin bad++; $display("FAIL gaps_err_count got=%0d want=1", err_count); end
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    exp_v = sb.pop_front(); total += 3;
    if (error_pulse !== exp_v.pulse || locked !== exp_v.lock) begin
      bad++;
      $display("FAIL clear_err got pulse=%b locked=%b want pulse=%b locked=%b",
               error_pulse, locked, exp_v.pulse, exp_v.lock);
    end
    if (err_count !== 16'd0) begin bad++; $display("FAIL clear_err_count got=%0d want=0", err_count); end
    if (bit_count !== 16'd0) begin bad++; $display("FAIL clear_bit_count got=%0d want=0", bit_count); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); total += 2;
    if (bit_count !== 16'd1) begin bad++; $display("FAIL post_clear_bit_count got=%0d want=1", bit_count); end
    if (locked !== exp_v.lock) begin bad++; $display("FAIL post_clear_locked got=%b want=%b", locked, exp_v.lock); end
  endtask

  task automatic test_reset_mid();
    logic inv;
    bring_up();
    for (int i = 0; i < 10; i++) begin
      inv = logic'(i inside {2, 4, 6});
      step(1'b1, inv, 1'b0, inv, 1'b1);
      exp_v = sb.pop_front(); total++;
      if (error_pulse !== exp_v.pulse || locked !== exp_v.lock) begin
        bad++;
        $display("FAIL mid_pre i=%0d got pulse=%b locked=%b want pulse=%b locked=%b",
                 i, error_pulse, locked, exp_v.pulse, exp_v.lock);
      end
    end
    total++;
    if (err_count !== 16'd3) begin bad++; $display("FAIL mid_err_count got=%0d want=3", err_count); end
    do_reset(1'b0);
    total += 3;
    if (locked !== 1'b0) begin bad++; $display("FAIL mid_reset_locked got=%b want=0", locked); end
    if (err_count !== 16'd0) begin bad++; $display("FAIL mid_reset_err_count got=%0d want=0", err_count); end
    if (bit_count !== 16'd0) begin bad++; $display("FAIL mid_reset_bit_count got=%0d want=0", bit_count); end
    for (int k = 1; k <= LOCK_BITS; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, logic'(k >= LOCK_BITS));
      exp_v = sb.pop_front(); total++;
      if (error_pulse !== exp_v.pulse || locked !== exp_v.lock) begin
        bad++;
        $display("FAIL mid_relock bit=%0d got pulse=%b locked=%b want pulse=%b locked=%b",
                 k, error_pulse, locked, exp_v.pulse, exp_v.lock);
      end
    end
  endtask

  initial begin
    gen = 10'h001;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_window();
    test_degenerate();
    test_gaps_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
